demux_1to4_stream: RTL and testbench

DEMUX_1TO4_STREAM -- requirements
Module: demux_1to4_stream

---
 rtl/demux_1to4_stream.sv | 88 ++++++++
 tb/tb_demux_1to4_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to4_stream.sv
// 1-to-4 stream demultiplexer with one registered output slot per channel,
// broadcast support and a wrapping per-channel count of accepted beats.
module demux_1to4_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [1:0]            in_sel,
    input  logic                  in_bcast,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic [4*CNT_W-1:0]    beat_cnt,
    input  logic                  clr_cnt
);

    logic                 rdy_q, rdy_d;
    logic [3:0]           full_q, full_d;
    logic [DATA_W-1:0]    data_q [4];
    logic [DATA_W-1:0]    data_d [4];
    logic [CNT_W-1:0]     cnt_q [4];
    logic [CNT_W-1:0]     cnt_d [4];
    logic [3:0]           free;
    logic [3:0]           wr;
    logic                 accept;

    assign out_valid = full_q;

    always_comb begin
        rdy_d    = 1'b1;
        // A slot draining this cycle can take a new beat in the same cycle.
        free     = ~full_q | out_ready;
        in_ready = 1'b0;
        if (in_bcast) begin
            in_ready = rdy_q & (&free);
        end else begin
            in_ready = rdy_q & free[in_sel];
        end
        accept = in_valid & in_ready;
        wr     = 4'b0000;
        if (accept) begin
            if (in_bcast) begin
                wr = 4'b1111;
            end else begin
                wr[in_sel] = 1'b1;
            end
        end
        out_data = '0;
        beat_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            full_d[k] = wr[k] | (full_q[k] & ~out_ready[k]);
            data_d[k] = wr[k] ? in_data : data_q[k];
            // Clear wins over a coinciding increment.
            if (clr_cnt) begin
                cnt_d[k] = '0;
            end else if (wr[k]) begin
                cnt_d[k] = cnt_q[k] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d[k] = cnt_q[k];
            end
            out_data[k*DATA_W +: DATA_W] = data_q[k];
            beat_cnt[k*CNT_W +: CNT_W]   = cnt_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            full_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            rdy_q  <= rdy_d;
            full_q <= full_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Scoreboard bench for demux_1to4_stream: per-channel expected-beat queues
// and counter model, directed scenarios followed by random traffic.
module tb_demux_1to4_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [1:0]          in_sel;
    logic                in_bcast;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready;
    logic [4*DATA_W-1:0] out_data;
    logic [4*CNT_W-1:0]  beat_cnt;
    logic                clr_cnt;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sb_q [4][$];
    logic [CNT_W-1:0]  cnt_m [4];
    logic              rdy_m;

    demux_1to4_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .beat_cnt  (beat_cnt),
        .clr_cnt   (clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Input handshake is allowed only from the first edge after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_m <= 1'b0;
        else        rdy_m <= 1'b1;
    end

    // Monitor / reference model: a channel holds a beat exactly when its
    // queue is non-empty; beats leave in order on out_valid & out_ready.
    always @(negedge clk) begin
        logic [3:0] free_m;
        logic       exp_rdy;
        logic [3:0] tgt;
        if (!rst_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
            chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
            for (int k = 0; k < 4; k++) begin
                sb_q[k].delete();
                cnt_m[k] = '0;
            end
        end else begin
            for (int k = 0; k < 4; k++)
                free_m[k] = (sb_q[k].size() == 0) || out_ready[k];
            exp_rdy = rdy_m && (in_bcast ? (&free_m) : free_m[in_sel]);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("out_valid%0d", k), 64'(out_valid[k]), 64'(sb_q[k].size() != 0));
                chk($sformatf("beat_cnt%0d", k), 64'(beat_cnt[k*CNT_W +: CNT_W]), 64'(cnt_m[k]));
                if (out_valid[k] && out_ready[k]) begin
                    if (sb_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dup_beat%0d actual=%0h required=none", k, out_data[k*DATA_W +: DATA_W]);
                    end else begin
                        chk($sformatf("out_data%0d", k), 64'(out_data[k*DATA_W +: DATA_W]), 64'(sb_q[k].pop_front()));
                    end
                end
            end
            tgt = 4'b0000;
            if (in_valid && exp_rdy) begin
                if (in_bcast) tgt = 4'b1111;
                else          tgt[in_sel] = 1'b1;
            end
            for (int k = 0; k < 4; k++) begin
                if (tgt[k]) sb_q[k].push_back(in_data);
                if (clr_cnt)     cnt_m[k] = '0;
                else if (tgt[k]) cnt_m[k] = cnt_m[k] + 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 2'd0;
        in_bcast = 1'b0; out_ready = 4'b1111; clr_cnt = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        chk("ready_after_release", 64'(in_ready), 64'd0);
        cyc(2);

        // Unicast 0xA5 to channel 2.
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
        cyc(1);
        in_valid = 1'b0;
        chk("uni_valid", 64'(out_valid), 64'h4);
        chk("uni_data", 64'(out_data[2*DATA_W +: DATA_W]), 64'hA5);
        chk("uni_cnt", 64'(beat_cnt[2*CNT_W +: CNT_W]), 64'd1);
        cyc(2);

        // Backpressure on channel 1.
        out_ready = 4'b1101;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
        cyc(1);
        in_data = 8'h22;
        cyc(5);
        out_ready = 4'b1111;
        cyc(1);
        in_valid = 1'b0;
        cyc(3);

        // Broadcast blocked by a stalled channel 3.
        out_ready = 4'b0111;
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h77;
        cyc(1);
        in_bcast = 1'b1; in_sel = 2'd0; in_data = 8'h3C;
        cyc(4);
        out_ready = 4'b1111;
        cyc(1);
        in_valid = 1'b0; in_bcast = 1'b0;
        chk("bcast_valid", 64'(out_valid), 64'hF);
        chk("bcast_data", 64'(out_data), 64'h3C3C3C3C);
        cyc(3);

        // Stream to channel 0 long enough to wrap its counter.
        clr_cnt = 1'b1;
        cyc(1);
        clr_cnt = 1'b0;
        in_valid = 1'b1; in_sel = 2'd0;
        for (int i = 0; i < 300; i++) begin
            in_data = DATA_W'($urandom);
            cyc(1);
        end

        // Clear coinciding with an accept.
        clr_cnt = 1'b1; in_data = 8'h5A;
        cyc(1);
        clr_cnt = 1'b0; in_valid = 1'b0;
        chk("clr_accept_cnt", 64'(beat_cnt[CNT_W-1:0]), 64'd0);
        cyc(2);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DATA_W'($urandom);
            in_sel    = 2'($urandom);
            in_bcast  = ($urandom_range(0, 7) == 0);
            out_ready = 4'($urandom);
            clr_cnt   = ($urandom_range(0, 31) == 0);
            cyc(1);
        end
        clr_cnt = 1'b0; in_bcast = 1'b0;

        // Reset asserted mid-stream.
        in_valid = 1'b1; in_sel = 2'd3; out_ready = 4'b0000;
        cyc(3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd0);
        cyc(2);
        rst_n = 1'b1;
        #1;
        chk("release_ready", 64'(in_ready), 64'd0);
        cyc(1);
        chk("ready_after_edge", 64'(in_ready), 64'd1);
        out_ready = 4'b1111;
        cyc(4);

        // Drain and confirm nothing was lost.
        in_valid = 1'b0;
        cyc(4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("drain_empty%0d", k), 64'(sb_q[k].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
